// File: rtl/mx_fp32_accum_if.sv
// ----------------------------------------------------------------------------
// mx_fp32_accum_if
//   Streaming bundle between the level-2 adder tree, the FP32 accumulator and
//   its result consumer.
//
//   Input stream (producer -> accumulator), valid/ready:
//     in_valid_i   partial sum valid
//     in_ready_o   accumulator can absorb a beat this cycle
//     in_mant_i    23b fraction (hidden 1 implied)
//     in_exp_i     FP32-biased exponent
//     in_sign_i    sign
//     in_zero_i    partial sum is exactly zero (mant/exp ignored)
//   Output stream (accumulator -> consumer), valid/ready:
//     out_valid_o  tile result valid
//     out_ready_i  consumer accepts the result
//     out_data_o   FP32 result {sign, exp[7:0], frac[22:0]}
//
//   Modports: slave = accumulator side, master = producer/consumer side.
// ----------------------------------------------------------------------------
interface mx_fp32_accum_if #(
    parameter int M_IN_WIDTH = 23
);
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [M_IN_WIDTH-1:0] in_mant_i;
    logic [7:0]            in_exp_i;
    logic                  in_sign_i;
    logic                  in_zero_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [31:0]           out_data_o;

    modport slave (
        input  in_valid_i, in_mant_i, in_exp_i, in_sign_i, in_zero_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o
    );

    modport master (
        output in_valid_i, in_mant_i, in_exp_i, in_sign_i, in_zero_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o
    );
endinterface

// File: rtl/mx_fp32_accum.sv
// ----------------------------------------------------------------------------
// mx_fp32_accum
//   Accumulates len_i+1 normalized FP32-style partial sums from the level-2
//   adder tree into one FP32 result per dot-product tile. One beat is aligned,
//   added and renormalized per cycle; guard bits are truncated (round toward
//   zero). Overflow saturates to the largest finite magnitude, underflow
//   flushes to +0.
//
//   Ports:
//     clk_i      clock
//     rstn       asynchronous active-low reset
//     start_i    begin a new tile (IDLE, or DONE together with out_ready_i)
//     len_i      beats-1 of the tile, latched with start_i
//     busy_o     state != IDLE
//     io         mx_fp32_accum_if.slave (input beat stream, result stream)
//     ovf_o      sticky per tile: a beat saturated    (MX_ACC_FLAGS_EN only)
//     uf_o       sticky per tile: a beat flushed to 0 (MX_ACC_FLAGS_EN only)
//
//   Build option: define MX_ACC_FLAGS_EN to expose ovf_o/uf_o. The arithmetic
//   is identical with or without the flags.
//
//   Parameters: M_IN_WIDTH must be 23 (FP32 fraction). GUARD_W guard bits
//   are carried below the LSB during align/add. LEN_W sizes len_i.
// ----------------------------------------------------------------------------
module mx_fp32_accum #(
    parameter int M_IN_WIDTH = 23,
    parameter int GUARD_W    = 3,
    parameter int LEN_W      = 8
) (
    input  logic             clk_i,
    input  logic             rstn,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
`ifdef MX_ACC_FLAGS_EN
    output logic             ovf_o,
    output logic             uf_o,
`endif
    mx_fp32_accum_if.slave   io
);

    // Magnitude layout: {hidden 1, fraction, guard bits}
    localparam int MAG_W = M_IN_WIDTH + 1 + GUARD_W;
    localparam int LZC_W = $clog2(MAG_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                state_q,     state_d;
    logic [LEN_W-1:0]      len_q,       len_d;
    logic [LEN_W-1:0]      cnt_q,       cnt_d;
    logic                  acc_sign_q,  acc_sign_d;
    logic [7:0]            acc_exp_q,   acc_exp_d;
    logic [M_IN_WIDTH-1:0] acc_frac_q,  acc_frac_d;
    logic                  busy_q,      busy_d;
    logic                  in_ready_q,  in_ready_d;
    logic                  out_valid_q, out_valid_d;
`ifdef MX_ACC_FLAGS_EN
    logic                  ovf_q,       ovf_d;
    logic                  uf_q,        uf_d;
`endif

    // ------------------------------------------------------------------
    // Leading-zero count over the pre-normalization magnitude
    // ------------------------------------------------------------------
    function automatic logic [LZC_W-1:0] lead_zeros(input logic [MAG_W-1:0] v);
        logic [LZC_W-1:0] n;
        logic             found;
        n     = '0;
        found = 1'b0;
        for (int i = MAG_W - 1; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) begin
                    found = 1'b1;
                end else begin
                    n = n + 1'b1;
                end
            end
        end
        return n;
    endfunction

    // ------------------------------------------------------------------
    // Datapath: acc + beat in a single cycle
    // ------------------------------------------------------------------
    logic                  a_zero, b_zero;
    logic [7:0]            a_exp, b_exp;
    logic [MAG_W-1:0]      a_mag, b_mag;
    logic                  a_is_base;
    logic                  base_sign, oth_sign;
    logic [7:0]            base_exp, oth_exp, exp_diff;
    logic [MAG_W-1:0]      base_mag, oth_mag, oth_shift;
    logic [MAG_W:0]        sum_mag;
    logic [LZC_W-1:0]      lz;
    logic [MAG_W-1:0]      norm_mag;
    logic signed [9:0]     exp_res;
    logic                  res_sign;
    logic [7:0]            res_exp;
    logic [M_IN_WIDTH-1:0] res_frac;
    logic                  res_ovf, res_uf;

    always_comb begin
        // A zero operand enters as magnitude 0 / exponent 0, so it always
        // loses the base selection and contributes nothing.
        a_zero = (acc_exp_q == 8'd0);
        b_zero = io.in_zero_i || (io.in_exp_i == 8'd0);
        a_exp  = a_zero ? 8'd0 : acc_exp_q;
        b_exp  = b_zero ? 8'd0 : io.in_exp_i;
        a_mag  = a_zero ? '0 : {1'b1, acc_frac_q, {GUARD_W{1'b0}}};
        b_mag  = b_zero ? '0 : {1'b1, io.in_mant_i, {GUARD_W{1'b0}}};

        // Base = larger exponent, ties broken by larger magnitude, so the
        // subtraction below never goes negative.
        a_is_base = (a_exp > b_exp) || ((a_exp == b_exp) && (a_mag >= b_mag));
        base_sign = a_is_base ? acc_sign_q : io.in_sign_i;
        oth_sign  = a_is_base ? io.in_sign_i : acc_sign_q;
        base_exp  = a_is_base ? a_exp : b_exp;
        oth_exp   = a_is_base ? b_exp : a_exp;
        base_mag  = a_is_base ? a_mag : b_mag;
        oth_mag   = a_is_base ? b_mag : a_mag;

        // Alignment without a sticky bit: bits shifted past the guard
        // window are simply lost.
        exp_diff  = base_exp - oth_exp;
        oth_shift = (int'(exp_diff) >= MAG_W) ? '0 : (oth_mag >> exp_diff);

        if (base_sign == oth_sign) begin
            sum_mag = {1'b0, base_mag} + {1'b0, oth_shift};
        end else begin
            sum_mag = {1'b0, base_mag} - {1'b0, oth_shift};
        end

        lz       = '0;
        norm_mag = '0;
        exp_res  = '0;
        res_sign = 1'b0;
        res_exp  = 8'd0;
        res_frac = '0;
        res_ovf  = 1'b0;
        res_uf   = 1'b0;

        if (sum_mag == '0) begin
            // Exact cancel (or zero + zero) gives +0 and is not an underflow.
            res_sign = 1'b0;
        end else begin
            if (sum_mag[MAG_W]) begin
                norm_mag = sum_mag[MAG_W:1];
                exp_res  = $signed({2'b00, base_exp}) + 10'sd1;
            end else begin
                lz       = lead_zeros(sum_mag[MAG_W-1:0]);
                norm_mag = sum_mag[MAG_W-1:0] << lz;
                exp_res  = $signed({2'b00, base_exp})
                         - $signed({{(10 - LZC_W){1'b0}}, lz});
            end

            if (exp_res >= 10'sd255) begin
                res_sign = base_sign;
                res_exp  = 8'hFE;
                res_frac = '1;
                res_ovf  = 1'b1;
            end else if (exp_res <= 10'sd0) begin
                res_uf   = 1'b1;
            end else begin
                res_sign = base_sign;
                res_exp  = exp_res[7:0];
                // Drop the hidden bit and truncate the guard bits.
                res_frac = norm_mag[MAG_W-2 -: M_IN_WIDTH];
            end
        end
    end

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    logic tile_start;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        acc_sign_d = acc_sign_q;
        acc_exp_d  = acc_exp_q;
        acc_frac_d = acc_frac_q;
`ifdef MX_ACC_FLAGS_EN
        ovf_d      = ovf_q;
        uf_d       = uf_q;
`endif
        tile_start = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    tile_start = 1'b1;
                    state_d    = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                // in_ready_q is high throughout ACCUM, so in_valid_i alone
                // marks a handshake here.
                if (io.in_valid_i && in_ready_q) begin
                    acc_sign_d = res_sign;
                    acc_exp_d  = res_exp;
                    acc_frac_d = res_frac;
                    cnt_d      = cnt_q + 1'b1;
`ifdef MX_ACC_FLAGS_EN
                    ovf_d      = ovf_q | res_ovf;
                    uf_d       = uf_q  | res_uf;
`endif
                    if (cnt_q == len_q) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // start_i only counts together with the result handshake.
                if (io.out_ready_i) begin
                    if (start_i) begin
                        tile_start = 1'b1;
                        state_d    = ST_ACCUM;
                    end else begin
                        state_d    = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (tile_start) begin
            len_d      = len_i;
            cnt_d      = '0;
            acc_sign_d = 1'b0;
            acc_exp_d  = 8'd0;
            acc_frac_d = '0;
`ifdef MX_ACC_FLAGS_EN
            ovf_d      = 1'b0;
            uf_d       = 1'b0;
`endif
        end

        // Outputs are registered from the next state.
        busy_d      = (state_d != ST_IDLE);
        in_ready_d  = (state_d == ST_ACCUM);
        out_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            acc_sign_q  <= 1'b0;
            acc_exp_q   <= 8'd0;
            acc_frac_q  <= '0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef MX_ACC_FLAGS_EN
            ovf_q       <= 1'b0;
            uf_q        <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            acc_sign_q  <= acc_sign_d;
            acc_exp_q   <= acc_exp_d;
            acc_frac_q  <= acc_frac_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef MX_ACC_FLAGS_EN
            ovf_q       <= ovf_d;
            uf_q        <= uf_d;
`endif
        end
    end

    // The accumulator register doubles as the result register; it is frozen
    // while in DONE, which keeps out_data_o stable until the handshake.
    assign busy_o         = busy_q;
    assign io.in_ready_o  = in_ready_q;
    assign io.out_valid_o = out_valid_q;
    assign io.out_data_o  = {acc_sign_q, acc_exp_q, acc_frac_q};
`ifdef MX_ACC_FLAGS_EN
    assign ovf_o          = ovf_q;
    assign uf_o           = uf_q;
`endif

endmodule

// File: tb/tb_mx_fp32_accum.sv
// ----------------------------------------------------------------------------
// tb_mx_fp32_accum
//   Directed tiles for mx_fp32_accum. Expected tile results are pushed into a
//   scoreboard queue when a tile's stimulus is issued and popped when the DUT
//   hands a result over. Flag checks are included when MX_ACC_FLAGS_EN is set.
// ----------------------------------------------------------------------------
module tb_mx_fp32_accum;

    logic       clk_i = 1'b0;
    logic       rstn;
    logic       start_i;
    logic [7:0] len_i;
    logic       busy_o;
`ifdef MX_ACC_FLAGS_EN
    logic       ovf_o;
    logic       uf_o;
`endif

    mx_fp32_accum_if #(.M_IN_WIDTH(23)) io ();

    mx_fp32_accum #(
        .M_IN_WIDTH (23),
        .GUARD_W    (3),
        .LEN_W      (8)
    ) dut (
        .clk_i   (clk_i),
        .rstn    (rstn),
        .start_i (start_i),
        .len_i   (len_i),
        .busy_o  (busy_o),
`ifdef MX_ACC_FLAGS_EN
        .ovf_o   (ovf_o),
        .uf_o    (uf_o),
`endif
        .io      (io)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        ovf;
        logic        uf;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
        end
    endtask

    task automatic push_exp(input string name, input logic [31:0] data,
                            input logic ovf, input logic uf);
        exp_t e;
        e.name = name;
        e.data = data;
        e.ovf  = ovf;
        e.uf   = uf;
        sb_q.push_back(e);
    endtask

    // Called at a negedge with the DUT idle.
    task automatic start_tile(input string name, input logic [7:0] len);
        start_i = 1'b1;
        len_i   = len;
        @(negedge clk_i);
        start_i = 1'b0;
        chk({name, ".in_ready"}, 32'(io.in_ready_o), 32'd1);
    endtask

    // Called at a negedge; returns at the negedge after the beat was taken.
    task automatic send_beat(input logic s, input logic [7:0] e,
                             input logic [22:0] m, input logic z);
        int guard;
        io.in_valid_i = 1'b1;
        io.in_sign_i  = s;
        io.in_exp_i   = e;
        io.in_mant_i  = m;
        io.in_zero_i  = z;
        guard = 0;
        while (io.in_ready_o !== 1'b1 && guard < 100) begin
            @(negedge clk_i);
            guard++;
        end
        if (guard >= 100) chk("beat_timeout", 32'd0, 32'd1);
        @(negedge clk_i);
        io.in_valid_i = 1'b0;
    endtask

    task automatic send_f(input logic [31:0] f);
        send_beat(f[31], f[30:23], f[22:0], 1'b0);
    endtask

    // Waits for a result, hands it over (optionally with a back-to-back
    // start) and compares it against the scoreboard head.
    task automatic take_output(input logic with_start, input logic [7:0] new_len);
        int          guard;
        logic [31:0] data;
        exp_t        e;
`ifdef MX_ACC_FLAGS_EN
        logic        ovf, uf;
`endif
        guard = 0;
        while (io.out_valid_o !== 1'b1 && guard < 100) begin
            @(negedge clk_i);
            guard++;
        end
        if (guard >= 100) begin
            chk("out_timeout", 32'd0, 32'd1);
            return;
        end
        data = io.out_data_o;
`ifdef MX_ACC_FLAGS_EN
        ovf  = ovf_o;
        uf   = uf_o;
`endif
        io.out_ready_i = 1'b1;
        start_i        = with_start;
        len_i          = new_len;
        @(negedge clk_i);
        io.out_ready_i = 1'b0;
        start_i        = 1'b0;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk(e.name, data, e.data);
`ifdef MX_ACC_FLAGS_EN
            chk({e.name, ".ovf"}, 32'(ovf), 32'(e.ovf));
            chk({e.name, ".uf"},  32'(uf),  32'(e.uf));
`endif
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn           = 1'b0;
        start_i        = 1'b0;
        len_i          = 8'd0;
        io.in_valid_i  = 1'b0;
        io.in_sign_i   = 1'b0;
        io.in_exp_i    = 8'd0;
        io.in_mant_i   = 23'd0;
        io.in_zero_i   = 1'b0;
        io.out_ready_i = 1'b0;

        // Reset state
        repeat (3) @(negedge clk_i);
        chk("rst.busy",      32'(busy_o),         32'd0);
        chk("rst.in_ready",  32'(io.in_ready_o),  32'd0);
        chk("rst.out_valid", 32'(io.out_valid_o), 32'd0);
        chk("rst.out_data",  io.out_data_o,       32'd0);
        rstn = 1'b1;
        @(negedge clk_i);
        chk("idle.busy",     32'(busy_o),         32'd0);

        // T1: single beat 1.0, result the cycle after the beat is accepted
        push_exp("T1", 32'h3F800000, 1'b0, 1'b0);
        start_tile("T1", 8'd0);
        chk("T1.busy", 32'(busy_o), 32'd1);
        send_f(32'h3F800000);
        chk("T1.latency", 32'(io.out_valid_o), 32'd1);
        take_output(1'b0, 8'd0);
        chk("T1.idle", 32'(busy_o), 32'd0);

        // T2: 1.0 + 2.0 - 0.5 + 0.25 = 2.75
        push_exp("T2", 32'h40300000, 1'b0, 1'b0);
        start_tile("T2", 8'd3);
        send_f(32'h3F800000);
        send_f(32'h40000000);
        send_f(32'hBF000000);
        send_f(32'h3E800000);
        take_output(1'b0, 8'd0);

        // T3: exact cancel to +0
        push_exp("T3", 32'h00000000, 1'b0, 1'b0);
        start_tile("T3", 8'd1);
        send_f(32'h3FC00000);
        send_f(32'hBFC00000);
        take_output(1'b0, 8'd0);

        // T4: result held under back-pressure, start ignored, then back-to-back
        push_exp("T4a", 32'h3FC00000, 1'b0, 1'b0);
        start_tile("T4a", 8'd0);
        send_f(32'h3FC00000);
        for (int i = 0; i < 5; i++) begin
            start_i = 1'b1;
            len_i   = 8'd0;
            @(negedge clk_i);
            chk("T4.hold_data",  io.out_data_o,       32'h3FC00000);
            chk("T4.hold_valid", 32'(io.out_valid_o), 32'd1);
            chk("T4.in_ready",   32'(io.in_ready_o),  32'd0);
        end
        start_i = 1'b0;
        push_exp("T4b", 32'hC0000000, 1'b0, 1'b0);
        take_output(1'b1, 8'd0);
        chk("T4.b2b_ready", 32'(io.in_ready_o),  32'd1);
        chk("T4.b2b_valid", 32'(io.out_valid_o), 32'd0);
        chk("T4.b2b_busy",  32'(busy_o),         32'd1);
        send_f(32'hC0000000);
        take_output(1'b0, 8'd0);

        // T5: overflow saturates to max finite
        push_exp("T5", 32'h7F7FFFFF, 1'b1, 1'b0);
        start_tile("T5", 8'd1);
        send_f(32'h7F7FFFFF);
        send_f(32'h7F7FFFFF);
        take_output(1'b0, 8'd0);

        // T6: zero-flagged beats and input gaps; busy held across the tile
        push_exp("T6", 32'h40400000, 1'b0, 1'b0);
        start_tile("T6", 8'd2);
        send_beat(1'b0, 8'd0, 23'd0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            chk("T6.busy_gap", 32'(busy_o), 32'd1);
        end
        send_f(32'h40400000);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            chk("T6.busy_gap", 32'(busy_o), 32'd1);
            chk("T6.no_valid", 32'(io.out_valid_o), 32'd0);
        end
        send_beat(1'b1, 8'd200, 23'h000123, 1'b1);
        chk("T6.busy_done", 32'(busy_o), 32'd1);
        take_output(1'b0, 8'd0);

        // T7: subnormal result flushes to +0, underflow stays sticky
        push_exp("T7", 32'h3F800000, 1'b0, 1'b1);
        start_tile("T7", 8'd2);
        send_beat(1'b0, 8'd1, 23'h400000, 1'b0);
        send_beat(1'b1, 8'd1, 23'h000000, 1'b0);
        send_f(32'h3F800000);
        take_output(1'b0, 8'd0);

        // T8: exponent gap 26, guard bit borrows, result truncated
        push_exp("T8", 32'h3F7FFFFF, 1'b0, 1'b0);
        start_tile("T8", 8'd1);
        send_f(32'h3F800000);
        send_beat(1'b1, 8'd101, 23'd0, 1'b0);
        take_output(1'b0, 8'd0);

        // T9: exponent gap 27 contributes nothing
        push_exp("T9", 32'h3F800000, 1'b0, 1'b0);
        start_tile("T9", 8'd1);
        send_f(32'h3F800000);
        send_beat(1'b1, 8'd100, 23'd0, 1'b0);
        take_output(1'b0, 8'd0);

        // T10: exponent 0 with nonzero fraction is a zero beat
        push_exp("T10", 32'hC0400000, 1'b0, 1'b0);
        start_tile("T10", 8'd1);
        send_beat(1'b0, 8'd0, 23'h7FFFFF, 1'b0);
        send_f(32'hC0400000);
        take_output(1'b0, 8'd0);

        // T11: longest tile, 256 beats of 1.0
        push_exp("T11", 32'h43800000, 1'b0, 1'b0);
        start_tile("T11", 8'd255);
        for (int i = 0; i < 256; i++) send_f(32'h3F800000);
        take_output(1'b0, 8'd0);

        // T12: reset mid-tile drops the tile
        start_tile("T12", 8'd3);
        send_f(32'h3F800000);
        rstn = 1'b0;
        #1;
        chk("T12.busy",      32'(busy_o),         32'd0);
        chk("T12.in_ready",  32'(io.in_ready_o),  32'd0);
        chk("T12.out_valid", 32'(io.out_valid_o), 32'd0);
        chk("T12.out_data",  io.out_data_o,       32'd0);
        @(negedge clk_i);
        rstn = 1'b1;
        @(negedge clk_i);

        // T13: normal operation after the mid-tile reset
        push_exp("T13", 32'h40A00000, 1'b0, 1'b0);
        start_tile("T13", 8'd0);
        send_f(32'h40A00000);
        take_output(1'b0, 8'd0);

        chk("sb.drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
